// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the MISA-O external memory arbiter.
package misao_mem_pkg;

  localparam int MEM_AW = 15;

  typedef enum logic [1:0] {
    NIBBLE = 2'b00,
    BYTE   = 2'b01,
    WORD   = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } arb_state_t;

  // The reserved size code behaves as a plain byte access.
  function automatic mem_size_t decode_size(input logic [1:0] size);
    return (size == 2'b11) ? BYTE : mem_size_t'(size);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input grant logic for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module mem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef MEM_ARB_RR_EN
  logic last1_q, last1_d;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    last1_d = last1_q;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last1_q;
        gnt1 = !last1_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      if (gnt0) begin
        last1_d = 1'b0;
      end else if (gnt1) begin
        last1_d = 1'b1;
      end
    end
  end

  // Reset to "port 1 granted last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last1_q <= 1'b1;
    end else begin
      last1_q <= last1_d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt0 = en && req0;
    gnt1 = en && req1 && !req0;
  end
`endif

endmodule

// File: rtl/misao_mem_arbiter.sv
// Shares the 8-bit MISA-O memory port between the core (port 0) and a loader (port 1).
// Tie-breaking policy is chosen by MEM_ARB_RR_EN inside mem_rr_arbiter.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch fields
// BEAT0 | low (or only) byte at addr
// BEAT1 | high byte of a word at addr+1
// RESP  | pulse owner's done with the read result
module misao_mem_arbiter
  import misao_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [1:0]    r0_size,
  input  logic [AW-1:0] r0_addr,
  input  logic [15:0]   r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [15:0]   r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [1:0]    r1_size,
  input  logic [AW-1:0] r1_addr,
  input  logic [15:0]   r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [15:0]   r1_rdata,
  output logic          mem_enable_read,
  output logic          mem_enable_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_out,
  input  logic [DW-1:0] mem_data_in
);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  mem_size_t     size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] hi_q, hi_d;
  logic          arb_en, gnt0, gnt1;
  logic [15:0]   rsp_data;

  // Gating with rst keeps gnt low while reset is held.
  assign arb_en = (state_q == IDLE) && rst;

  mem_rr_arbiter u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (r0_req),
    .req1 (r1_req),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    we_d             = we_q;
    size_d           = size_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    lo_d             = lo_q;
    hi_d             = hi_q;
    r0_gnt           = gnt0;
    r1_gnt           = gnt1;
    r0_done          = 1'b0;
    r1_done          = 1'b0;
    r0_rdata         = 16'h0000;
    r1_rdata         = 16'h0000;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_addr         = '0;
    mem_data_out     = '0;
    rsp_data         = 16'h0000;

    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          we_d    = gnt1 ? r1_we : r0_we;
          size_d  = decode_size(gnt1 ? r1_size : r0_size);
          addr_d  = gnt1 ? r1_addr : r0_addr;
          wdata_d = gnt1 ? r1_wdata : r0_wdata;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_enable_write = 1'b1;
          mem_data_out     = (size_q == NIBBLE) ? {4'h0, wdata_q[3:0]} : wdata_q[7:0];
        end else begin
          mem_enable_read = 1'b1;
          lo_d            = mem_data_in;
        end
        state_d = (size_q == WORD) ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_addr = addr_q + {{(AW-1){1'b0}}, 1'b1};
        if (we_q) begin
          mem_enable_write = 1'b1;
          mem_data_out     = wdata_q[15:8];
        end else begin
          mem_enable_read = 1'b1;
          hi_d            = mem_data_in;
        end
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) begin
          case (size_q)
            NIBBLE:  rsp_data = {12'h000, lo_q[3:0]};
            WORD:    rsp_data = {hi_q, lo_q};
            default: rsp_data = {8'h00, lo_q};
          endcase
        end
        if (owner_q) begin
          r1_done  = 1'b1;
          r1_rdata = rsp_data;
        end else begin
          r0_done  = 1'b1;
          r0_rdata = rsp_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= NIBBLE;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Scoreboard bench for misao_mem_arbiter with a behavioural byte memory.
module tb_misao_mem_arbiter;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req, r0_we, r0_gnt, r0_done;
  logic [1:0]    r0_size;
  logic [AW-1:0] r0_addr;
  logic [15:0]   r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_gnt, r1_done;
  logic [1:0]    r1_size;
  logic [AW-1:0] r1_addr;
  logic [15:0]   r1_wdata, r1_rdata;
  logic          mem_enable_read, mem_enable_write;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data_out, mem_data_in;

  logic [7:0] mem [0:32767];
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          port;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  misao_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  assign mem_data_in = mem_enable_read ? mem[mem_addr] : 8'h00;
  always @(posedge clk) if (mem_enable_write) mem[mem_addr] <= mem_data_out;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (r0_done || r1_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got r0_done=%0b r1_done=%0b expected none", r0_done, r1_done);
      end else begin
        e = sb.pop_front();
        chk("done_port", {31'd0, r1_done}, {31'd0, e.port});
        chk("done_onehot", {30'd0, r1_done, r0_done}, e.port ? 32'd2 : 32'd1);
        chk("rdata", {16'd0, (r1_done ? r1_rdata : r0_rdata)}, {16'd0, e.rdata});
        chk("rdata_other", {16'd0, (r1_done ? r0_rdata : r1_rdata)}, 32'd0);
      end
    end
  end

  task automatic access(input bit p, input bit we, input logic [1:0] sz, input logic [AW-1:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int exp_lat,
                        input string name);
    int c0;
    bit got;
    sb.push_back('{p, we ? 16'h0000 : exp_rd});
    @(negedge clk);
    if (p) begin
      r1_we = we; r1_size = sz; r1_addr = a; r1_wdata = wd; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_size = sz; r0_addr = a; r0_wdata = wd; r0_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p ? r1_gnt : r0_gnt) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    c0 = cyc;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_gnt: got no grant expected grant within 20 cycles", name);
      void'(sb.pop_back());
      r0_req = 1'b0;
      r1_req = 1'b0;
      return;
    end
    @(negedge clk);
    r0_req = 1'b0;
    r1_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (p ? r1_done : r0_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_lat"}, got ? (cyc - c0) : -1, exp_lat);
  endtask

  initial begin
    bit exp_p [4];
    int n;
    r0_req = 0; r0_we = 0; r0_size = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_size = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", {30'd0, mem_enable_read, mem_enable_write}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_dout", {24'd0, mem_data_out}, 32'd0);
    chk("rst_ctrl", {28'd0, r0_gnt, r1_gnt, r0_done, r1_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    access(0, 1, 2'b01, 15'h0081, 16'h005B, 16'h0000, 2, "p0_wr_byte");
    chk("mem_0081", {24'd0, mem[15'h0081]}, 32'h5B);
    access(0, 0, 2'b01, 15'h0081, 16'h0000, 16'h005B, 2, "p0_rd_byte");
    access(0, 1, 2'b00, 15'h0080, 16'h00A5, 16'h0000, 2, "p0_wr_nib");
    chk("mem_0080", {24'd0, mem[15'h0080]}, 32'h05);
    access(0, 0, 2'b00, 15'h0080, 16'h0000, 16'h0005, 2, "p0_rd_nib");
    access(0, 0, 2'b11, 15'h0081, 16'h0000, 16'h005B, 2, "p0_rd_rsv");
    access(1, 1, 2'b10, 15'h0090, 16'h1234, 16'h0000, 3, "p1_wr_word");
    chk("mem_0090", {24'd0, mem[15'h0090]}, 32'h34);
    chk("mem_0091", {24'd0, mem[15'h0091]}, 32'h12);
    access(1, 0, 2'b10, 15'h0090, 16'h0000, 16'h1234, 3, "p1_rd_word");
    access(1, 1, 2'b10, 15'h7FFF, 16'hBEEF, 16'h0000, 3, "p1_wr_wrap");
    chk("mem_7fff", {24'd0, mem[15'h7FFF]}, 32'hEF);
    chk("mem_0000", {24'd0, mem[15'h0000]}, 32'hBE);
    access(0, 0, 2'b10, 15'h7FFF, 16'h0000, 16'hBEEF, 3, "p0_rd_wrap");

    // Setup writes; the last grant goes to port 1 so port 0 leads the tie sequence.
    access(0, 1, 2'b01, 15'h0020, 16'h0011, 16'h0000, 2, "setup_20");
    access(0, 1, 2'b01, 15'h0011, 16'h0077, 16'h0000, 2, "setup_11");
    access(0, 1, 2'b01, 15'h0010, 16'h0066, 16'h0000, 2, "setup_10");
    access(1, 1, 2'b01, 15'h0021, 16'h0022, 16'h0000, 2, "setup_21");

`ifdef MEM_ARB_RR_EN
    exp_p = '{0, 1, 0, 1};
`else
    exp_p = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) sb.push_back('{exp_p[k], exp_p[k] ? 16'h0022 : 16'h0011});
    @(negedge clk);
    r0_we = 0; r0_size = 2'b01; r0_addr = 15'h0020; r0_req = 1'b1;
    r1_we = 0; r1_size = 2'b01; r1_addr = 15'h0021; r1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      if (r0_gnt || r1_gnt) begin
        chk("arb_gnt", {31'd0, r1_gnt}, {31'd0, exp_p[n]});
        n++;
      end
      @(negedge clk);
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    chk("arb_count", n, 4);
    repeat (5) @(negedge clk);

    r0_we = 1; r0_size = 2'b10; r0_addr = 15'h0010; r0_wdata = 16'hCAFE; r0_req = 1'b1;
    #1;
    chk("rst_mid_gnt", {31'd0, r0_gnt}, 32'd1);
    @(negedge clk);
    chk("rst_mid_we", {31'd0, mem_enable_write}, 32'd1);
    rst = 1'b0;
    r0_req = 1'b0;
    #1;
    chk("rst_mid_strobes", {30'd0, mem_enable_read, mem_enable_write}, 32'd0);
    chk("rst_mid_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_mid_dout", {24'd0, mem_data_out}, 32'd0);
    chk("rst_mid_ctrl", {28'd0, r0_gnt, r1_gnt, r0_done, r1_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_mem10", {24'd0, mem[15'h0010]}, 32'h66);
    chk("rst_mid_mem11", {24'd0, mem[15'h0011]}, 32'h77);
    access(0, 0, 2'b01, 15'h0011, 16'h0000, 16'h0077, 2, "post_rst_rd");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/misao_mem_arbiter.md
# misao_mem_arbiter

Shares the single 8-bit MISA-O external memory port (15-bit address, combinational read, posedge write) between two requesters: the core (port 0) and an external loader/debug master (port 1). It arbitrates between them and turns each granted request into one or two byte beats. A nibble or byte access takes one beat; a 16-bit word (LK16) access takes two little-endian beats. The block sits between `misao` request logic and the memory pins.

## Interface
Parameters:
- `AW`, 15: memory address width.
- `DW`, 8: memory data width (fixed; words are 2*DW).

Ports (`rN_*` repeated for N = 0, 1):
- `clk`  in  1: single clock, all state on posedge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rN_req`  in  1: request; `rN_we`, `rN_size`, `rN_addr` and `rN_wdata` are held stable while high.
- `rN_we`  in  1: 1 = write, 0 = read.
- `rN_size`  in  2: 00 nibble, 01 byte, 10 word, 11 reserved (treated as byte).
- `rN_addr`  in  AW: base address.
- `rN_wdata`  in  16: write data.
- `rN_gnt`  out  1: one-cycle pulse; request accepted and fields latched.
- `rN_done`  out  1: one-cycle pulse; access complete.
- `rN_rdata`  out  16: read result, valid while `rN_done` is high; 0 otherwise.
- `mem_enable_read`  out  1: read strobe.
- `mem_enable_write`  out  1: write strobe; memory commits at the posedge.
- `mem_addr`  out  AW: beat address.
- `mem_data_out`  out  DW: write byte.
- `mem_data_in`  in  DW: read byte, valid in the same cycle as `mem_enable_read`.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - If any `rN_req` is high, pick a winner, pulse its `gnt`, latch `we`, `size`, `addr` and `wdata`, and go to BEAT0.
  - If no request is high, stay in IDLE.
- BEAT0:
  - Drive `mem_addr` = addr.
  - Assert the read or write strobe.
  - Write data:
    - nibble: `{4'h0, wdata[3:0]}`
    - byte: `wdata[7:0]`
    - word: `wdata[7:0]`
  - Reads capture `mem_data_in` at the posedge.
  - Go to BEAT1 if size = word, otherwise go to RESP.
- BEAT1:
  - Drive `mem_addr` = addr+1, modulo 2^AW (0x7FFF wraps to 0x0000).
  - Write data: `wdata[15:8]`.
  - Reads capture the high byte.
  - Go to RESP.
- RESP:
  - Pulse the owner's `done` and drive its `rdata`.
  - Read results:
    - nibble: `{12'h0, byte[3:0]}`
    - byte: `{8'h0, byte}`
    - word: `{hi, lo}`
  - Go to IDLE.
- Strobes are never asserted outside BEAT0 and BEAT1.
- Only one strobe is asserted at a time.
- `mem_data_out` is 0 when not writing.
- Arbitration is per `Configuration`. A request arriving while the block is busy waits; it is not dropped.
- A requester deasserting `req` before `gnt` withdraws its request; no side effects.
- Post-increment/decrement of RA registers stays in the core. This block only adds +1 for the high byte.

## Timing
- Reset state: FSM = IDLE, all outputs 0, round-robin pointer = "last granted 1", so port 0 wins the first tie.
- Byte or nibble access:
  - cycle 0: `gnt` (IDLE)
  - cycle 1: strobe
  - cycle 2: `done`
  - Total 3 cycles from the first `gnt` to the next IDLE.
- Word access:
  - cycle 0: `gnt`
  - cycles 1–2: strobes
  - cycle 3: `done`
- A next request held continuously is granted the cycle after `done`.
- Reset asserted mid-access aborts immediately: strobes drop asynchronously and no `done` is issued. A word write can leave only the low byte written; this is accepted behaviour.

## Configuration
- `MEM_ARB_RR_EN` defined: two-way round-robin. On a tie, grant the port not granted last; the pointer updates on each `gnt`.
- Undefined: fixed priority, port 0 always wins ties. The pointer logic is not compiled.

## Structure
- `misao_mem_pkg` holds:
  - `mem_size_t` (NIBBLE, BYTE, WORD)
  - `arb_state_t` (IDLE, BEAT0, BEAT1, RESP)
  - `MEM_AW = 15`
- One sub-module, `mem_rr_arbiter`: 2-input grant logic plus the last-grant pointer, selected by the macro.
- The beat FSM stays in the top module.

## Test plan
- Port 0 byte write 0x5B to 0x0081, then byte read from 0x0081 -> memory[0x81] = 0x5B; `r0_rdata` = 0x005B on `done`, 2 cycles after `gnt`.
- Port 0 nibble write wdata = 0x00A5 to 0x0080 -> memory[0x80] = 0x05; nibble read returns 0x0005.
- Port 1 word write 0x1234 to 0x0090 -> memory[0x90] = 0x34, memory[0x91] = 0x12; word read returns 0x1234 on `done`, 3 cycles after `gnt`.
- Word write 0xBEEF to 0x7FFF -> memory[0x7FFF] = 0xEF, memory[0x0000] = 0xBE (address wrap).
- Both ports request continuously, byte reads:
  - With `MEM_ARB_RR_EN`: grants alternate 0, 1, 0, 1, starting with port 0.
  - Without it: port 0 gets every grant while held.
- Assert `rst` low during BEAT0 of a word write to 0x0010 -> strobes drop the same cycle, memory[0x11] is unchanged, no `done`, outputs 0, FSM in IDLE after release.
